// File: rtl/beat_sequencer_ctrl.sv
// rtl/beat_sequencer_ctrl.sv - play/pause/stop sequencer stepping a beat index at a tempo-scaled rate
module beat_sequencer_ctrl #(
  parameter int BASE_DIV = 1_562_500,
  parameter int BEAT_MAX = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        stop,
  input  logic        tempo_up,
  input  logic        tempo_down,
  input  logic        loop_en,
  output logic [11:0] ibeat_num,
  output logic        en,
  output logic [1:0]  state,
  output logic [2:0]  tempo_idx,
  output logic        beat_tick
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] BASE_DIV_W = 32'(BASE_DIV);
  localparam logic [11:0] LAST_BEAT  = 12'(BEAT_MAX - 1);
  localparam logic [11:0] BEAT_END   = 12'(BEAT_MAX);
  localparam logic [2:0]  TEMPO_RST  = 3'd3;

  state_t      state_q, state_d;
  logic [11:0] ibeat_q, ibeat_d;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic [31:0] period_q, period_d;
  logic [2:0]  tempo_q, tempo_d;
  logic        tick_q, tick_d;
  logic        en_q, en_d;

  logic [31:0] new_period;
  logic        beat_adv;

  // Period is sampled only at beat starts so a tempo change never stretches or cuts the running beat.
  assign new_period = BASE_DIV_W * (32'd8 - {29'd0, tempo_q});
  assign beat_adv   = (state_q == S_PLAY) && (div_cnt_q == period_q - 32'd1);

  always_comb begin
    state_d   = state_q;
    ibeat_d   = ibeat_q;
    div_cnt_d = div_cnt_q;
    period_d  = period_q;
    tempo_d   = tempo_q;
    tick_d    = 1'b0;

    if (tempo_up && !tempo_down && tempo_q != 3'd7) begin
      tempo_d = tempo_q + 3'd1;
    end else if (tempo_down && !tempo_up && tempo_q != 3'd0) begin
      tempo_d = tempo_q - 3'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (play && !stop) begin
          state_d   = S_PLAY;
          ibeat_d   = 12'd0;
          div_cnt_d = 32'd0;
          period_d  = new_period;
        end
      end
      S_PLAY: begin
        if (stop) begin
          state_d   = S_IDLE;
          ibeat_d   = 12'd0;
          div_cnt_d = 32'd0;
        end else if (beat_adv) begin
          div_cnt_d = 32'd0;
          if (ibeat_q != LAST_BEAT || loop_en) begin
            ibeat_d  = (ibeat_q == LAST_BEAT) ? 12'd0 : ibeat_q + 12'd1;
            tick_d   = 1'b1;
            period_d = new_period;
            if (play) begin
              state_d = S_PAUSE;
            end
          end else begin
            ibeat_d = BEAT_END;
            state_d = S_DONE;
          end
        end else if (play) begin
          state_d = S_PAUSE;
        end else begin
          div_cnt_d = div_cnt_q + 32'd1;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d   = S_IDLE;
          ibeat_d   = 12'd0;
          div_cnt_d = 32'd0;
        end else if (play) begin
          state_d = S_PLAY;
        end
      end
      S_DONE: begin
        if (stop) begin
          state_d   = S_IDLE;
          ibeat_d   = 12'd0;
          div_cnt_d = 32'd0;
        end else if (play) begin
          state_d   = S_PLAY;
          ibeat_d   = 12'd0;
          div_cnt_d = 32'd0;
          period_d  = new_period;
        end
      end
      default: state_d = S_IDLE;
    endcase

    en_d = (state_d == S_PLAY) || (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ibeat_q   <= 12'd0;
      div_cnt_q <= 32'd0;
      period_q  <= BASE_DIV_W * 32'd5;
      tempo_q   <= TEMPO_RST;
      tick_q    <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ibeat_q   <= ibeat_d;
      div_cnt_q <= div_cnt_d;
      period_q  <= period_d;
      tempo_q   <= tempo_d;
      tick_q    <= tick_d;
      en_q      <= en_d;
    end
  end

  assign ibeat_num = ibeat_q;
  assign en        = en_q;
  assign state     = state_q;
  assign tempo_idx = tempo_q;
  assign beat_tick = tick_q;

endmodule

// File: tb/tb_beat_sequencer_ctrl.sv
// tb/tb_beat_sequencer_ctrl.sv - scoreboard bench for beat_sequencer_ctrl with BASE_DIV=2, BEAT_MAX=4
module tb_beat_sequencer_ctrl;

  localparam int BASE_DIV = 2;
  localparam int BEAT_MAX = 4;

  localparam int S_BEAT  = 0;
  localparam int S_STATE = 1;
  localparam int S_EN    = 2;
  localparam int S_TEMPO = 3;
  localparam int S_TICK  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        tempo_up = 1'b0;
  logic        tempo_down = 1'b0;
  logic        loop_en = 1'b0;
  logic [11:0] ibeat_num;
  logic        en;
  logic [1:0]  state;
  logic [2:0]  tempo_idx;
  logic        beat_tick;

  beat_sequencer_ctrl #(.BASE_DIV(BASE_DIV), .BEAT_MAX(BEAT_MAX)) dut (
    .clk(clk), .rst(rst), .play(play), .stop(stop),
    .tempo_up(tempo_up), .tempo_down(tempo_down), .loop_en(loop_en),
    .ibeat_num(ibeat_num), .en(en), .state(state),
    .tempo_idx(tempo_idx), .beat_tick(beat_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  function automatic int observe(input int sig);
    case (sig)
      S_BEAT:  return int'(ibeat_num);
      S_STATE: return int'(state);
      S_EN:    return int'(en);
      S_TEMPO: return int'(tempo_idx);
      S_TICK:  return int'(beat_tick);
      default: return -1;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input int val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_ctl(input string tag, input int st, input int beat);
    expect_val({tag, "_state"}, S_STATE, st);
    expect_val({tag, "_en"}, S_EN, (st == 1 || st == 3) ? 1 : 0);
    expect_val({tag, "_beat"}, S_BEAT, beat);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, then every pending expectation is retired.
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sig), e.val);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    expect_ctl("rst", 0, 0);
    expect_val("rst_tempo", S_TEMPO, 3);
    expect_val("rst_tick", S_TICK, 0);
    cyc();
    rst = 1'b1;

    // Full pattern without loop: 10-cycle beats at tempo 3
    play = 1'b1;
    expect_ctl("start", 1, 0);
    cyc();
    play = 1'b0;
    for (int c = 1; c < 40; c++) begin
      expect_val("run_beat", S_BEAT, c / 10);
      expect_val("run_tick", S_TICK, (c % 10 == 0) ? 1 : 0);
      cyc();
    end
    expect_ctl("done", 3, 4);
    expect_val("done_tick", S_TICK, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      expect_ctl("done_hold", 3, 4);
      cyc();
    end
    stop = 1'b1;
    expect_ctl("done_stop", 0, 0);
    cyc();
    stop = 1'b0;

    play = 1'b1;
    stop = 1'b1;
    expect_ctl("idle_play_stop", 0, 0);
    cyc();
    play = 1'b0;
    stop = 1'b0;

    // Tempo saturation and simultaneous up/down
    for (int i = 1; i <= 5; i++) begin
      tempo_up = 1'b1;
      expect_val("tempo_up", S_TEMPO, (3 + i > 7) ? 7 : 3 + i);
      cyc();
      tempo_up = 1'b0;
    end
    tempo_up = 1'b1;
    tempo_down = 1'b1;
    expect_val("tempo_both", S_TEMPO, 7);
    cyc();
    tempo_up = 1'b0;
    expect_val("tempo_down", S_TEMPO, 6);
    cyc();
    tempo_down = 1'b0;

    // Tempo 6 = 4-cycle beat; tempo_up mid-beat keeps it 4, next beat is 2
    play = 1'b1;
    expect_ctl("t6_start", 1, 0);
    cyc();
    play = 1'b0;
    tempo_up = 1'b1;
    expect_val("t7_mid", S_TEMPO, 7);
    expect_val("t7_mid_beat", S_BEAT, 0);
    cyc();
    tempo_up = 1'b0;
    for (int c = 2; c < 8; c++) begin
      expect_val("tchg_beat", S_BEAT, (c < 4) ? 0 : ((c < 6) ? 1 : 2));
      expect_val("tchg_tick", S_TICK, (c == 4 || c == 6) ? 1 : 0);
      cyc();
    end
    stop = 1'b1;
    expect_ctl("tchg_stop", 0, 0);
    cyc();
    stop = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tempo_down = 1'b1;
      expect_val("tempo_back", S_TEMPO, 7 - i);
      cyc();
      tempo_down = 1'b0;
    end

    // Pause at div_cnt 3 of beat 1, then resume with 7 cycles left
    play = 1'b1;
    expect_ctl("p_start", 1, 0);
    cyc();
    play = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      expect_val("p_run", S_BEAT, c / 10);
      cyc();
    end
    play = 1'b1;
    expect_ctl("pause", 2, 1);
    cyc();
    play = 1'b0;
    for (int i = 1; i < 20; i++) begin
      expect_ctl("pause_hold", 2, 1);
      cyc();
    end
    play = 1'b1;
    expect_ctl("resume", 1, 1);
    cyc();
    play = 1'b0;
    for (int i = 1; i < 7; i++) begin
      expect_ctl("resume_run", 1, 1);
      expect_val("resume_tick", S_TICK, 0);
      cyc();
    end
    expect_ctl("resume_adv", 1, 2);
    expect_val("resume_adv_tick", S_TICK, 1);
    cyc();
    play = 1'b1;
    stop = 1'b1;
    expect_ctl("play_stop", 0, 0);
    cyc();
    play = 1'b0;
    stop = 1'b0;

    // Looping, then stop landing on a beat advance
    loop_en = 1'b1;
    play = 1'b1;
    expect_ctl("l_start", 1, 0);
    cyc();
    play = 1'b0;
    for (int c = 1; c < 50; c++) begin
      expect_ctl("loop", 1, (c / 10) % 4);
      expect_val("loop_tick", S_TICK, (c % 10 == 0) ? 1 : 0);
      cyc();
    end
    stop = 1'b1;
    expect_ctl("stop_adv", 0, 0);
    expect_val("stop_adv_tick", S_TICK, 0);
    cyc();
    stop = 1'b0;
    loop_en = 1'b0;

    // Reset during PAUSE at beat 2, tempo 6
    for (int i = 1; i <= 3; i++) begin
      tempo_up = 1'b1;
      expect_val("t_to6", S_TEMPO, 3 + i);
      cyc();
      tempo_up = 1'b0;
    end
    play = 1'b1;
    expect_ctl("r_start", 1, 0);
    cyc();
    play = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      expect_val("r_run", S_BEAT, c / 4);
      cyc();
    end
    play = 1'b1;
    expect_ctl("r_pause", 2, 2);
    expect_val("r_pause_tempo", S_TEMPO, 6);
    cyc();
    play = 1'b0;
    cyc();
    rst = 1'b0;
    play = 1'b1;
    expect_ctl("rst_pause", 0, 0);
    expect_val("rst_pause_tempo", S_TEMPO, 3);
    expect_val("rst_pause_tick", S_TICK, 0);
    cyc();
    rst = 1'b1;
    play = 1'b0;
    expect_ctl("post_rst", 0, 0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/beat_sequencer_ctrl.md
BEAT_SEQUENCER_CTRL -- requirements
Module: beat_sequencer_ctrl

Interface
REQ-001 Parameter: BASE_DIV, 1_562_500, clock cycles per tempo unit (beat period = BASE_DIV*(8-tempo_idx)).
REQ-002 Parameter: BEAT_MAX, 64, number of beats in one pattern; legal range 1..4095.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 play  input  1  single-cycle pulse (pre-debounced): start / pause / resume.
REQ-006 stop  input  1  single-cycle pulse: abort to IDLE.
REQ-007 tempo_up  input  1  single-cycle pulse: increment tempo_idx.
REQ-008 tempo_down  input  1  single-cycle pulse: decrement tempo_idx.
REQ-009 loop_en  input  1  level; 1 = restart pattern after last beat.
REQ-010 ibeat_num  output  12  current beat index, registered; drives the step-tone datapath.
REQ-011 en  output  1  registered; 1 = datapath enabled (PLAY or DONE).
REQ-012 state  output  2  registered: IDLE=0, PLAY=1, PAUSE=2, DONE=3.
REQ-013 tempo_idx  output  3  registered; 0 = slowest, 7 = fastest.
REQ-014 beat_tick  output  1  registered one-cycle pulse, high in the first cycle a new ibeat_num value is visible during PLAY.

Function
REQ-015 Internal divider div_cnt counts 0..period-1; period latched at every beat start (entry to PLAY from IDLE/DONE, and each beat advance) as BASE_DIV*(8-tempo_idx).
REQ-016 Tempo change mid-beat SHALL NOT alter the current beat's length; new period applies from next beat start.
REQ-017 tempo_up: tempo_idx+1, saturating at 7; tempo_down: tempo_idx-1, saturating at 0; both in same cycle: no change; accepted in every state.
REQ-018 IDLE: play -> PLAY, ibeat_num=0, div_cnt=0; stop ignored; en=0.
REQ-019 PLAY: div_cnt increments each cycle; at div_cnt==period-1: div_cnt<=0 and beat advance.
REQ-020 Beat advance with ibeat_num<BEAT_MAX-1: ibeat_num+1, beat_tick=1 next cycle.
REQ-021 Beat advance at ibeat_num==BEAT_MAX-1: loop_en=1 -> ibeat_num=0, stay PLAY, beat_tick=1; loop_en=0 -> ibeat_num=BEAT_MAX, state DONE, beat_tick=0.
REQ-022 PLAY: play -> PAUSE, ibeat_num and div_cnt held; stop -> IDLE, ibeat_num=0, div_cnt=0.
REQ-023 PAUSE: en=0, all counters held; play -> PLAY resuming same div_cnt (remaining beat time preserved); stop -> IDLE, ibeat_num=0.
REQ-024 DONE: en=1, ibeat_num held at BEAT_MAX (datapath silent, all-LED pattern); play -> PLAY from ibeat_num=0; stop -> IDLE.
REQ-025 play and stop in same cycle: stop wins in every state (IDLE: no change).
REQ-026 play coinciding with a beat advance in PLAY: PAUSE taken, advance still applied (ibeat_num updated, div_cnt=0), beat_tick=1.
REQ-027 stop coinciding with beat advance: IDLE wins, ibeat_num=0, beat_tick=0.
REQ-028 en = 1 exactly when state is PLAY or DONE, updated on the same edge as state.
REQ-029 Control latency: input pulse sampled at edge k -> state/en/ibeat_num change visible after edge k (one cycle).
REQ-030 Arithmetic: div_cnt and period 32-bit unsigned; ibeat_num never exceeds BEAT_MAX.

Reset
REQ-031 rst low at a rising edge: state=IDLE, ibeat_num=0, en=0, tempo_idx=3, beat_tick=0, div_cnt=0, period=BASE_DIV*5.
REQ-032 Reset has priority over all inputs, including mid-beat and in PAUSE/DONE; no output changes between edges.

Verification (BASE_DIV=2, BEAT_MAX=4)
REQ-033 Reset, play pulse, loop_en=0, tempo_idx=3 -> ibeat 0,1,2,3 each held 10 cycles with beat_tick per advance, then state=DONE, ibeat_num=4, en=1.
REQ-034 Four tempo_up pulses then play -> tempo_idx=7, beat length 2 cycles; a fifth tempo_up keeps 7; tempo_up mid-beat does not shorten that beat.
REQ-035 PLAY, play pulse at div_cnt=3 of beat 1 -> PAUSE, en=0 for 20 cycles, ibeat_num=1; play -> beat 1 ends after remaining 7 cycles.
REQ-036 loop_en=1 -> after ibeat_num=3 wraps to 0 with beat_tick=1, state stays PLAY.
REQ-037 play and stop same cycle in PLAY -> IDLE, ibeat_num=0; stop on beat-advance cycle -> IDLE, beat_tick=0.
REQ-038 rst low during PAUSE at ibeat_num=2, tempo_idx=6 -> next cycle IDLE, ibeat_num=0, tempo_idx=3, en=0.
